pid_channel_scheduler: RTL and testbench
========================================

Name: pid_channel_scheduler

Overview:
- Time-multiplexes one shared pid_controller-style datapath across NUM_CH independent control loops.
- An internal sample timer starts a sweep every SAMPLE_DIV clocks.
- Each sweep serves the enabled channels in ascending index order. Per channel it restores the saved integrator/derivative state, starts the datapath, waits for completion, then stores the result and the new state.
- Sits between the top-level pad mapping and the datapath; owns all per-channel state storage.

Parameters:
- NUM_CH, 4, number of control channels (2..8)
- DW, 8, setpoint/feedback/control width
- SW, 16, opaque per-channel datapath state width
- SAMPLE_DIV, 1000, clocks per sample period (>= 8)
- TIMEOUT, 255, max WAIT cycles before abandoning a channel

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ch_en  in  NUM_CH  per-channel enable
- setpoint_flat  in  NUM_CH*DW  channel i at [i*DW +: DW]
- feedback_flat  in  NUM_CH*DW  same packing
- clr_err  in  1  clears sticky error flags
- dp_start  out  1  one-cycle start pulse to datapath
- dp_ch  out  clog2(NUM_CH)  channel being served
- dp_setpoint  out  DW  registered operand
- dp_feedback  out  DW  registered operand
- dp_state_in  out  SW  restored channel state
- dp_done  in  1  datapath completion pulse
- dp_result  in  DW  control value, valid with dp_done
- dp_state_out  in  SW  updated state, valid with dp_done
- control_flat  out  NUM_CH*DW  last control value per channel
- ctrl_valid  out  NUM_CH  one-cycle update strobe per channel
- busy  out  1  high whenever FSM not IDLE
- overrun  out  1  sticky: tick arrived while busy
- timeout_err  out  1  sticky: datapath exceeded TIMEOUT

Behaviour:
- Reset (async, rst=1): every output 0, every state memory word 0, timer 0, FSM IDLE.
- Timer:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high for one cycle when count == SAMPLE_DIV-1.
  - First tick occurs in the SAMPLE_DIV-th cycle after reset release.
- FSM states: IDLE, LOAD, START, WAIT, STORE.
- IDLE:
  - On tick, snapshot ch_en into en_q.
  - For every i with ch_en[i]=0, clear state_mem[i] to 0.
  - If en_q != 0, set cur = lowest set bit and go to LOAD; else stay IDLE.
- LOAD: register setpoint[cur], feedback[cur], state_mem[cur] and dp_ch=cur onto dp_* outputs; go to START.
- START: dp_start=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT:
  - dp_done=1: capture dp_result and dp_state_out, go to STORE.
  - Wait counter reaches TIMEOUT: set timeout_err, skip the store (control and state of cur unchanged), advance as in STORE.
- STORE:
  - Write control[cur] and state_mem[cur]; ctrl_valid[cur] is high the following cycle, alongside the new control value.
  - Advance cur to the next set bit of en_q above cur and go to LOAD; if none, go to IDLE.
- dp_done outside WAIT is ignored.
- dp_* operand outputs hold their last values when not in LOAD.
- tick in any non-IDLE state: set overrun and drop the tick; the current sweep continues unaffected.
- ch_en changes mid-sweep take effect at the next tick only.
- clr_err clears both sticky flags. If set and clear events occur in the same cycle, set wins.
- Latency with an immediate dp_done:
  - tick at cycle T, LOAD at T+1, dp_start at T+2.
  - dp_done at T+3, STORE at T+4, ctrl_valid and new control at T+5.
  - One channel costs 4 cycles plus datapath latency.
- Disabled channels keep their last control value.

Decomposition:
- Package pid_sched_pkg: FSM state enum, CH_W = clog2(NUM_CH), and a priority-find-next-set-bit function.
- Sub-module pid_sample_timer (SAMPLE_DIV counter, tick output), reusable elsewhere.
- State memory and control registers stay inline as register arrays.

Test Plan:
- Basic sweep: NUM_CH=4, SAMPLE_DIV=16, ch_en=4'b1111, datapath model returns setpoint-feedback after 2 cycles, setpoints 10/20/30/40 with feedback 0 -> control 10,20,30,40; ctrl_valid[0..3] pulse in order; busy drops after last STORE.
- Sparse enable: ch_en=4'b1010 -> dp_ch sequence 1 then 3 only; control[0] and control[2] stay 0; state_mem[0] and state_mem[2] are cleared.
- State round-trip: model returns dp_state_out = dp_state_in+1 -> channel 2 sees dp_state_in 0,1,2 on successive ticks; after disabling and re-enabling channel 2 it sees 0.
- Timeout: model never asserts dp_done on channel 1, TIMEOUT=5 -> timeout_err set; control[1] unchanged; channel 2 still served in the same sweep; clr_err clears the flag.
- Overrun: datapath latency 20, SAMPLE_DIV=16 -> overrun set at the second tick; no extra sweep starts; the sweep completes normally.
- Reset mid-WAIT: assert rst during WAIT -> all outputs 0 immediately. After release, the first tick comes after SAMPLE_DIV cycles and a late dp_done is ignored.

Source files
------------

// File: rtl/pid_sched_pkg.sv
// Shared types and helpers for the PID channel scheduler: FSM encoding,
// channel-index width and a find-next-enabled-channel priority search.
package pid_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    STORE
  } sched_state_t;

  localparam int MAX_CH = 8;
  localparam int IDX_W  = 3;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns {found, index} of the lowest set bit of mask at or above from.
  function automatic logic [IDX_W:0] find_set(input logic [MAX_CH-1:0] mask, input int from);
    logic [IDX_W:0] hit;
    hit = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) hit = {1'b1, IDX_W'(i)};
    end
    return hit;
  endfunction

endpackage

// File: rtl/pid_channel_scheduler_if.sv
// Scheduler <-> shared PID datapath link: registered operands plus a start pulse out,
// completion pulse with result/state back; no backpressure, datapath answers when done.
interface pid_channel_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int SW     = 16
) ();

  localparam int CH_W = pid_sched_pkg::ch_width(NUM_CH);

  logic            dp_start;
  logic [CH_W-1:0] dp_ch;
  logic [DW-1:0]   dp_setpoint;
  logic [DW-1:0]   dp_feedback;
  logic [SW-1:0]   dp_state_in;
  logic            dp_done;
  logic [DW-1:0]   dp_result;
  logic [SW-1:0]   dp_state_out;

  modport master (
    output dp_start, dp_ch, dp_setpoint, dp_feedback, dp_state_in,
    input  dp_done, dp_result, dp_state_out
  );

  modport slave (
    input  dp_start, dp_ch, dp_setpoint, dp_feedback, dp_state_in,
    output dp_done, dp_result, dp_state_out
  );

endinterface

// File: rtl/pid_sample_timer.sv
// Free-running 0..DIV-1 counter with a one-cycle tick on the last count;
// first tick DIV cycles after reset release, no backpressure.
module pid_sample_timer #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/pid_channel_scheduler.sv
// Sweeps enabled channels through one shared PID datapath each sample tick; 4 cycles
// plus datapath latency per channel; ticks arriving mid-sweep are dropped and flagged.
module pid_channel_scheduler
  import pid_sched_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DW         = 8,
  parameter int SW         = 16,
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      ch_en,
  input  logic [NUM_CH*DW-1:0]   setpoint_flat,
  input  logic [NUM_CH*DW-1:0]   feedback_flat,
  input  logic                   clr_err,
  pid_channel_scheduler_if.master dp,
  output logic [NUM_CH*DW-1:0]   control_flat,
  output logic [NUM_CH-1:0]      ctrl_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  sched_state_t     state;
  logic             tick;
  logic [NUM_CH-1:0] en_q;
  logic [CH_W-1:0]  cur;
  logic [WC_W-1:0]  wcnt;
  logic [DW-1:0]    res_q;
  logic [SW-1:0]    st_q;
  logic [SW-1:0]    state_mem [NUM_CH];
  logic [DW-1:0]    control   [NUM_CH];
  logic [IDX_W:0]   first_hit;
  logic [IDX_W:0]   next_hit;
  logic             overrun_hit;
  logic             timeout_hit;

  pid_sample_timer #(.DIV(SAMPLE_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign first_hit   = find_set(MAX_CH'(ch_en), 0);
  assign next_hit    = find_set(MAX_CH'(en_q), int'(cur) + 1);
  assign overrun_hit = tick && (state != IDLE);
  assign timeout_hit = (state == WAIT) && !dp.dp_done && (wcnt == WC_W'(TIMEOUT));
  assign busy        = (state != IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ctrl
    assign control_flat[g*DW +: DW] = control[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      en_q           <= '0;
      cur            <= '0;
      wcnt           <= '0;
      res_q          <= '0;
      st_q           <= '0;
      dp.dp_start    <= 1'b0;
      dp.dp_ch       <= '0;
      dp.dp_setpoint <= '0;
      dp.dp_feedback <= '0;
      dp.dp_state_in <= '0;
      ctrl_valid     <= '0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_mem[i] <= '0;
        control[i]   <= '0;
      end
    end else begin
      ctrl_valid  <= '0;
      dp.dp_start <= 1'b0;

      // A new error event in the same cycle as clr_err keeps the flag set.
      if (overrun_hit)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            en_q <= ch_en;
            for (int i = 0; i < NUM_CH; i++) begin
              if (!ch_en[i]) state_mem[i] <= '0;
            end
            if (first_hit[IDX_W]) begin
              cur   <= CH_W'(first_hit[IDX_W-1:0]);
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          dp.dp_ch       <= cur;
          dp.dp_setpoint <= setpoint_flat[int'(cur)*DW +: DW];
          dp.dp_feedback <= feedback_flat[int'(cur)*DW +: DW];
          dp.dp_state_in <= state_mem[cur];
          dp.dp_start    <= 1'b1;
          state          <= START;
        end
        START: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (dp.dp_done) begin
            res_q <= dp.dp_result;
            st_q  <= dp.dp_state_out;
            state <= STORE;
          end else if (wcnt == WC_W'(TIMEOUT)) begin
            // Abandon this channel without touching its control or state.
            if (next_hit[IDX_W]) begin
              cur   <= CH_W'(next_hit[IDX_W-1:0]);
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        STORE: begin
          control[cur]    <= res_q;
          state_mem[cur]  <= st_q;
          ctrl_valid[cur] <= 1'b1;
          if (next_hit[IDX_W]) begin
            cur   <= CH_W'(next_hit[IDX_W-1:0]);
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed bench for pid_channel_scheduler with a behavioural datapath
// (result = setpoint - feedback, state_out = state_in + 1, programmable latency).
module tb_pid_channel_scheduler;

  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int SW   = 16;
  localparam int SDIV = 32;
  localparam int TOUT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic [31:0] setpoint_flat;
  logic [31:0] feedback_flat;
  logic        clr_err;
  logic [31:0] control_flat;
  logic [3:0]  ctrl_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  pid_channel_scheduler_if #(.NUM_CH(NCH), .DW(DW), .SW(SW)) dpi ();

  pid_channel_scheduler #(
    .NUM_CH(NCH), .DW(DW), .SW(SW), .SAMPLE_DIV(SDIV), .TIMEOUT(TOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_en         (ch_en),
    .setpoint_flat (setpoint_flat),
    .feedback_flat (feedback_flat),
    .clr_err       (clr_err),
    .dp            (dpi),
    .control_flat  (control_flat),
    .ctrl_valid    (ctrl_valid),
    .busy          (busy),
    .overrun       (overrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Datapath model, updated on the falling edge so the DUT sees stable inputs.
  int          lat     = 2;
  int          hang_ch = -1;
  int          mcnt    = 0;
  bit          pend    = 1'b0;
  logic        md_done = 1'b0;
  logic [7:0]  md_res  = '0;
  logic [15:0] md_st   = '0;
  logic [7:0]  msp     = '0;
  logic [7:0]  mfb     = '0;
  logic [15:0] mst     = '0;

  assign dpi.dp_done      = md_done;
  assign dpi.dp_result    = md_res;
  assign dpi.dp_state_out = md_st;

  always @(negedge clk) begin
    md_done = 1'b0;
    if (pend) begin
      mcnt--;
      if (mcnt <= 0) begin
        pend    = 1'b0;
        md_done = 1'b1;
        md_res  = msp - mfb;
        md_st   = mst + 16'd1;
      end
    end
    if (dpi.dp_start && (int'(dpi.dp_ch) != hang_ch)) begin
      pend = 1'b1;
      mcnt = lat;
      msp  = dpi.dp_setpoint;
      mfb  = dpi.dp_feedback;
      mst  = dpi.dp_state_in;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [31:0] sp;
    logic [31:0] fb;
    int          hang;
    logic [31:0] exp_ctrl;
    logic [15:0] exp_seq;
    logic [15:0] exp_vseq;
    logic [31:0] exp_st;
    logic        exp_to;
  } vec_t;

  vec_t        vec [8];
  logic [15:0] seq;
  logic [15:0] vseq;
  logic [31:0] st_seen;

  // Waits for a sweep, logs served channels (dp_start order) and update strobes.
  task automatic run_sweep(input string tag, input logic [31:0] exp_ctrl);
    int n;
    seq     = '0;
    vseq    = '0;
    st_seen = '1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 3 * SDIV);
    chk({tag, "_start"}, 64'(busy), 64'd1);
    n = 0;
    forever begin
      if (dpi.dp_start) begin
        seq = {seq[11:0], 2'b10, dpi.dp_ch};
        st_seen[int'(dpi.dp_ch)*8 +: 8] = dpi.dp_state_in[7:0];
      end
      for (int i = 0; i < NCH; i++) begin
        if (ctrl_valid[i]) begin
          vseq = {vseq[11:0], 4'(8 + i)};
          chk($sformatf("%s_ctrl_at_valid%0d", tag, i), 64'(control_flat[i*8 +: 8]),
              64'(exp_ctrl[i*8 +: 8]));
        end
      end
      if (!busy || n >= 300) break;
      @(negedge clk);
      n++;
    end
    chk({tag, "_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          n;
    logic [35:0] acc;

    vec[0] = '{4'b1111, 32'h281E140A, 32'h00000000, -1, 32'h281E140A, 16'h89AB, 16'h89AB, 32'h00000000, 1'b0};
    vec[1] = '{4'b1010, 32'h50463C32, 32'h05050505, -1, 32'h4B1E370A, 16'h009B, 16'h009B, 32'h01FF01FF, 1'b0};
    vec[2] = '{4'b0100, 32'h00640000, 32'h00010000, -1, 32'h4B63370A, 16'h000A, 16'h000A, 32'hFF00FFFF, 1'b0};
    vec[3] = '{4'b0100, 32'h00640000, 32'h00020000, -1, 32'h4B62370A, 16'h000A, 16'h000A, 32'hFF01FFFF, 1'b0};
    vec[4] = '{4'b0100, 32'h00640000, 32'h00030000, -1, 32'h4B61370A, 16'h000A, 16'h000A, 32'hFF02FFFF, 1'b0};
    vec[5] = '{4'b1011, 32'h04030201, 32'h00000000, -1, 32'h04610201, 16'h089B, 16'h089B, 32'h00FF0000, 1'b0};
    vec[6] = '{4'b0100, 32'h00070000, 32'h00070000, -1, 32'h04000201, 16'h000A, 16'h000A, 32'hFF00FFFF, 1'b0};
    vec[7] = '{4'b0110, 32'h000C0900, 32'h00020200,  1, 32'h040A0201, 16'h009A, 16'h000A, 32'hFF0100FF, 1'b1};

    rst           = 1'b1;
    ch_en         = '0;
    setpoint_flat = '0;
    feedback_flat = '0;
    clr_err       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, overrun, timeout_err, ctrl_valid, control_flat}), 64'd0);
    chk("reset_dp", 64'({dpi.dp_start, dpi.dp_ch, dpi.dp_setpoint, dpi.dp_feedback, dpi.dp_state_in}), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      ch_en         = vec[v].en;
      setpoint_flat = vec[v].sp;
      feedback_flat = vec[v].fb;
      hang_ch       = vec[v].hang;
      run_sweep($sformatf("v%0d", v), vec[v].exp_ctrl);
      chk($sformatf("v%0d_control", v), 64'(control_flat), 64'(vec[v].exp_ctrl));
      chk($sformatf("v%0d_dp_ch_seq", v), 64'(seq), 64'(vec[v].exp_seq));
      chk($sformatf("v%0d_valid_seq", v), 64'(vseq), 64'(vec[v].exp_vseq));
      chk($sformatf("v%0d_state_in", v), 64'(st_seen), 64'(vec[v].exp_st));
      chk($sformatf("v%0d_timeout_err", v), 64'(timeout_err), 64'(vec[v].exp_to));
      chk($sformatf("v%0d_overrun", v), 64'(overrun), 64'd0);
    end

    // Sticky timeout flag clears on clr_err.
    hang_ch = -1;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err_timeout", 64'(timeout_err), 64'd0);

    // Overrun: 4 channels x (5 + 3) cycles fill the whole 32-cycle period.
    lat           = 5;
    ch_en         = 4'b1111;
    setpoint_flat = 32'h2C21160B;
    feedback_flat = 32'h01010101;
    run_sweep("ovr1", 32'h2B20150A);
    chk("ovr1_seq", 64'(seq), 64'h89AB);
    chk("ovr1_control", 64'(control_flat), 64'h2B20150A);
    chk("ovr1_overrun_set", 64'(overrun), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 2 * SDIV);
    chk("ovr_no_extra_sweep", 64'(n), 64'(SDIV));
    run_sweep("ovr2", 32'h2B20150A);
    chk("ovr2_seq", 64'(seq), 64'h89AB);

    // Reset in the middle of WAIT, then a late dp_done while IDLE.
    ch_en         = 4'b0001;
    setpoint_flat = 32'h00000037;
    feedback_flat = 32'h00000000;
    n = 0;
    while (!dpi.dp_start && n < 4 * SDIV) begin
      @(negedge clk);
      n++;
    end
    chk("rst_start_seen", 64'(dpi.dp_start), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 64'({busy, overrun, timeout_err, ctrl_valid, control_flat}), 64'd0);
    chk("rst_async_dp", 64'({dpi.dp_start, dpi.dp_ch, dpi.dp_setpoint, dpi.dp_feedback, dpi.dp_state_in}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    acc = '0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      acc = acc | {ctrl_valid, control_flat};
    end while (!busy && n < 2 * SDIV);
    chk("rst_first_tick", 64'(n), 64'(SDIV));
    chk("rst_late_done_ignored", 64'(acc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
